sub_8_bit_serial: RTL and testbench



---
 rtl/sub_8_bit_serial.sv | 136 +++++++++++++
 tb/tb_sub_8_bit_serial.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sub_8_bit_serial.sv
`default_nettype none
// ============================================================================
//  Module      : sub_8_bit_serial
//  Description : Bit-serial subtractor, Diff = A - B - bin, one bit per clock
//                LSB first, framed by a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_8_bit_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             BorrowOut,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ma_q, ma_d;
    logic             mb_q, mb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             w_bit;
    logic             w_br;
    logic [WIDTH-1:0] w_res;

    // Full-subtractor slice on the current LSBs of the operand shift registers
    assign w_bit = a_q[0] ^ b_q[0] ^ br_q;
    assign w_br  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign w_res = {w_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    ma_d    = A[WIDTH-1];
                    mb_d    = B[WIDTH-1];
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = w_br;
                res_d = w_res;
                cnt_d = cnt_q + CW'(1);
                // Visible outputs only move on the final bit, never mid-shift
                if (cnt_q == C_LAST) begin
                    diff_d  = w_res;
                    bout_d  = w_br;
                    ovf_d   = (ma_q != mb_q) && (w_bit != ma_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            ma_q    <= 1'b0;
            mb_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign Diff      = diff_q;
    assign BorrowOut = bout_q;
    assign Overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_8_bit_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sub_8_bit_serial
//  Description : Directed self-checking bench for the serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_8_bit_serial;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] Diff;
    logic       BorrowOut;
    logic       Overflow;

    int         total;
    int         bad;
    logic [7:0] last_diff;

    sub_8_bit_serial #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .Diff      (Diff),
        .BorrowOut (BorrowOut),
        .Overflow  (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is positioned just after a falling edge with the block idle
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic bi, input logic [7:0] ed, input logic eb, input logic eo);
        int   k;
        int   busy_n;
        int   hold_err;
        logic seen;
        A = a; B = b; bin = bi; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; bin = ~bi;
        check_eq({tag, "/accept"}, busy, 1);
        busy_n   = busy ? 1 : 0;
        hold_err = 0;
        seen     = 1'b0;
        k        = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
            else if (Diff !== last_diff) hold_err++;
        end
        check_eq({tag, "/latency"}, k, 8);
        check_eq({tag, "/busy_cycles"}, busy_n, 9);
        check_eq({tag, "/hold"}, hold_err, 0);
        check_eq({tag, "/diff"}, Diff, ed);
        check_eq({tag, "/borrow"}, BorrowOut, eb);
        check_eq({tag, "/ovf"}, Overflow, eo);
        last_diff = ed;
        @(negedge clk);
        check_eq({tag, "/done_drop"}, done, 0);
        check_eq({tag, "/busy_drop"}, busy, 0);
    endtask

    initial begin
        int         dcnt;
        int         fk;
        logic [7:0] xa, xb;
        logic       xc;
        logic [8:0] full;
        logic [7:0] ed;

        total = 0; bad = 0; last_diff = 8'h00;
        rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst/busy", busy, 0);
        check_eq("rst/done", done, 0);
        check_eq("rst/diff", Diff, 0);
        check_eq("rst/borrow", BorrowOut, 0);
        check_eq("rst/ovf", Overflow, 0);

        run_op("one_minus_one", 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op("wrap",          8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("neg_ovf",       8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("bin_ovf",       8'h55, 8'hAA, 1'b1, 8'hAA, 1'b1, 1'b1);
        run_op("ff_ff_bin",     8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("pos_ovf",       8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);
        run_op("zero_bin",      8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

        // start pulses while busy (shift cycle 3 and the done cycle) are ignored
        A = 8'hF0; B = 8'h0F; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        dcnt = 0; fk = -1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            start = (k == 2 || k == 8);
            A     = start ? 8'h00 : 8'h33;
            B     = start ? 8'h00 : 8'h44;
            if (done) begin
                dcnt++;
                if (fk < 0) fk = k;
            end
        end
        start = 1'b0;
        check_eq("busy_start/done_count", dcnt, 1);
        check_eq("busy_start/done_at", fk, 8);
        check_eq("busy_start/diff", Diff, 8'hE1);
        check_eq("busy_start/borrow", BorrowOut, 0);
        check_eq("busy_start/ovf", Overflow, 0);
        last_diff = 8'hE1;

        // Reset at shift cycle 4 abandons the operation
        A = 8'h10; B = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst/busy", busy, 0);
        check_eq("midrst/done", done, 0);
        check_eq("midrst/diff", Diff, 0);
        check_eq("midrst/borrow", BorrowOut, 0);
        last_diff = 8'h00;
        run_op("after_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

        // start held high: accepts at edges 0, 10, 20
        xa = 8'h00; xb = 8'h00; xc = 1'b0;
        for (int k = 0; k < 30; k++) begin
            A     = 8'(k * 37 + 5);
            B     = 8'(k * 91 + 200);
            bin   = (k % 3 == 0);
            start = 1'b1;
            if (k % 10 == 0) begin
                xa = A; xb = B; xc = bin;
            end
            @(negedge clk);
            check_eq($sformatf("stream/done_k%0d", k), done, (k % 10 == 8));
            if (k % 10 == 8) begin
                full = {1'b0, xa} - {1'b0, xb} - {8'h00, xc};
                ed   = full[7:0];
                check_eq($sformatf("stream/borrow_k%0d", k), BorrowOut, full[8]);
                check_eq($sformatf("stream/ovf_k%0d", k), Overflow,
                         (xa[7] != xb[7]) && (ed[7] != xa[7]));
                last_diff = ed;
            end
            check_eq($sformatf("stream/diff_k%0d", k), Diff, last_diff);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
